// File: rtl/ttc_chanb_transmitter.sv
// TTC channel-B short-broadcast encoder: pending request flags, arbitration,
// Hamming protection and serialisation of 16-bit frames on bit_strobe.
module ttc_chanb_transmitter #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_strobe,
  input  logic        tx_enable,
  input  logic        req_fill,
  input  logic [2:0]  fill_type_in,
  input  logic        req_counter_reset,
  input  logic        req_evt_count_reset,
  input  logic        req_pulse_start,
  input  logic        req_pulse_stop,
  output logic        chan_b_serial,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [15:0] bad_req_count
);

  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_cr_pend;
  logic          r_ecr_pend;
  logic          r_fill_pend;
  logic [2:0]    r_fill_type;
  logic          r_pulse_pend;
  logic          r_pulse_stop;
  logic [15:0]   r_shift;
  logic [3:0]    r_bit_idx;
  logic [GW-1:0] r_gap_cnt;
  logic          r_serial;
  logic [31:0]   r_frames;
  logic [15:0]   r_bad;

  logic        w_any_pend;
  logic        w_gap_last;
  logic        w_load;
  logic        w_shift_adv;
  logic        w_stop_done;
  logic        w_gap_adv;
  logic        w_take_cr;
  logic        w_take_fill;
  logic        w_take_pulse;
  logic        w_fill_ok;
  logic        w_preq;
  logic [7:0]  w_fill_byte;
  logic [7:0]  w_byte;
  logic [4:0]  w_h;
  logic [15:0] w_frame;
  logic [1:0]  w_bad_inc;
  logic [16:0] w_bad_sum;

  assign w_any_pend  = r_cr_pend | r_ecr_pend | r_fill_pend | r_pulse_pend;
  assign w_gap_last  = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);
  assign w_load      = bit_strobe && tx_enable && w_any_pend &&
                       ((r_state == S_IDLE) || w_gap_last);
  assign w_stop_done = w_shift_adv && (r_bit_idx == 4'd15);

  assign w_take_cr    = w_load && r_cr_pend;
  assign w_take_fill  = w_load && !r_cr_pend && r_fill_pend;
  assign w_take_pulse = w_load && !r_cr_pend && !r_fill_pend && r_pulse_pend;

  assign w_fill_ok = (fill_type_in != 3'd0) && (fill_type_in <= 3'd4);
  assign w_preq    = req_pulse_start | req_pulse_stop;

  always_comb begin
    w_fill_byte = 8'h00;
    unique case (r_fill_type)
      3'b100:  w_fill_byte = 8'h80;
      3'b001:  w_fill_byte = 8'hA0;
      3'b010:  w_fill_byte = 8'hC0;
      3'b011:  w_fill_byte = 8'hE0;
      default: w_fill_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    unique case (1'b1)
      r_cr_pend:                   w_byte = 8'h28;
      !r_cr_pend && r_fill_pend:   w_byte = w_fill_byte;
      !r_cr_pend && !r_fill_pend && r_pulse_pend:
        w_byte = r_pulse_stop ? 8'hA8 : 8'h88;
      default:                     w_byte = 8'h00;
    endcase
    w_byte[1] = w_byte[1] | r_ecr_pend;
  end

  assign w_h[0] = w_byte[0] ^ w_byte[1] ^ w_byte[2] ^ w_byte[3];
  assign w_h[1] = w_byte[0] ^ w_byte[4] ^ w_byte[5] ^ w_byte[6];
  assign w_h[2] = w_byte[1] ^ w_byte[2] ^ w_byte[4] ^ w_byte[5] ^ w_byte[7];
  assign w_h[3] = w_byte[1] ^ w_byte[3] ^ w_byte[4] ^ w_byte[6] ^ w_byte[7];
  assign w_h[4] = ^{w_byte, w_h[3:0]};
  assign w_frame = {2'b00, w_byte, w_h, 1'b1};

  // overwrite of a flag that is being consumed this cycle is not an error
  assign w_bad_inc =
    2'(req_fill && (!w_fill_ok || (r_fill_pend && !w_take_fill))) +
    2'(req_pulse_start && req_pulse_stop) +
    2'(w_preq && r_pulse_pend && !w_take_pulse);
  assign w_bad_sum = {1'b0, r_bad} + 17'(w_bad_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_SHIFT;
      S_SHIFT: if (w_stop_done) w_next = S_GAP;
      S_GAP:   if (bit_strobe && w_gap_last)
                 w_next = w_load ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    w_shift_adv = (r_state == S_SHIFT) && bit_strobe;
    w_gap_adv   = (r_state == S_GAP) && bit_strobe && !w_gap_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cr_pend    <= 1'b0;
      r_ecr_pend   <= 1'b0;
      r_fill_pend  <= 1'b0;
      r_fill_type  <= 3'd0;
      r_pulse_pend <= 1'b0;
      r_pulse_stop <= 1'b0;
      r_bad        <= 16'd0;
    end else begin
      if (req_counter_reset)   r_cr_pend <= 1'b1;
      else if (w_take_cr)      r_cr_pend <= 1'b0;
      if (req_evt_count_reset) r_ecr_pend <= 1'b1;
      else if (w_load)         r_ecr_pend <= 1'b0;
      if (req_fill && w_fill_ok) begin
        r_fill_pend <= 1'b1;
        r_fill_type <= fill_type_in;
      end else if (w_take_fill) begin
        r_fill_pend <= 1'b0;
      end
      if (w_preq) begin
        r_pulse_pend <= 1'b1;
        r_pulse_stop <= req_pulse_stop;
      end else if (w_take_pulse) begin
        r_pulse_pend <= 1'b0;
      end
      r_bad <= w_bad_sum[16] ? 16'hFFFF : w_bad_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_serial  <= 1'b1;
      r_shift   <= 16'hFFFF;
      r_bit_idx <= 4'd0;
      r_gap_cnt <= '0;
      r_frames  <= 32'd0;
    end else begin
      if (w_load) begin
        r_serial  <= w_frame[15];
        r_shift   <= {w_frame[14:0], 1'b1};
        r_bit_idx <= 4'd0;
      end else if (w_shift_adv) begin
        r_serial <= r_shift[15];
        r_shift  <= {r_shift[14:0], 1'b1};
        if (r_bit_idx != 4'd15) r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_stop_done)    r_gap_cnt <= '0;
      else if (w_gap_adv) r_gap_cnt <= r_gap_cnt + 1'b1;
      if (w_stop_done) r_frames <= r_frames + 32'd1;
    end
  end

  assign chan_b_serial = r_serial;
  assign frames_sent   = r_frames;
  assign bad_req_count = r_bad;

endmodule
